adder5_frame_accumulator: RTL and testbench

Downstream consumer of the 5-bit adder stage. Takes each {carry_out, sum} result as a 6-bit unsigned beat over a valid/ready handshake and accumulates a frame of BEATS beats into an ACC_W-bit total. It then presents the total and a sticky overflow flag on a valid/ready output port. It sits between the adder datapath and the benchmark's result sink, and turns the combinational adder into a streaming reduction stage.

---
 rtl/adder5_pkg.sv | 21 ++
 rtl/adder5_beat_counter.sv | 43 ++++
 rtl/adder5_frame_accumulator.sv | 118 +++++++++++
 tb/tb_adder5_frame_accumulator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder5_pkg.sv
// Shared types and constants for the adder5 frame accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   state_e   : frame accumulator FSM states
//   OPER_W    : width of one {carry, sum} beat operand
//   cnt_width : beat counter width for a given frame length
package adder5_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int OPER_W = 6;

    // At least one bit, even for the smallest legal frame of 2 beats.
    function automatic int cnt_width(input int beats);
        return (beats <= 2) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/adder5_beat_counter.sv
// Beat counter for one frame; wraps to zero on the beat that completes a frame.
// Latency: last is combinational from the registered count.
// Backpressure: none; the caller gates inc with its own handshake.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one accepted beat
//   clr        : synchronous clear, wins over inc
//   last       : count equals BEATS-1 (the next accepted beat ends the frame)
module adder5_beat_counter #(
    parameter int BEATS = 8,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == LAST_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adder5_frame_accumulator.sv
// Sums frames of BEATS 6-bit {carry, sum} beats into an ACC_W-bit total with sticky overflow.
// Latency: out_valid rises on the edge that captures the last beat of a frame.
// Backpressure: in_ready drops while a result is held; in_ready depends only on state.
//   clk, rst_n           : clock, async active-low reset
//   clr                  : abort the partial frame (ignored while a result is held)
//   in_sum, in_carry     : beat operand {in_carry, in_sum}
//   in_valid / in_ready  : input handshake
//   out_data, out_ovf    : frame total modulo 2^ACC_W, overflow seen in the frame
//   out_valid / out_ready: output handshake
module adder5_frame_accumulator
    import adder5_pkg::*;
#(
    parameter int BEATS = 8,
    parameter int ACC_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [4:0]       in_sum,
    input  logic             in_carry,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = cnt_width(BEATS);
    localparam int SUM_W = ACC_W + 1;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic [SUM_W-1:0] oper_ext;
    logic [SUM_W-1:0] sum;
    logic             clr_accum;
    logic             beat_add;
    logic             cnt_last;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // A clear in ACCUM still shows in_ready, but the same-cycle beat is dropped.
    assign clr_accum = clr & in_ready;
    assign beat_add  = in_valid & in_ready & ~clr;

    // One extra bit on top of the accumulator captures the carry of each add.
    assign oper_ext = SUM_W'({in_carry, in_sum});
    assign sum      = {1'b0, acc_q} + oper_ext;

    adder5_beat_counter #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (beat_add),
        .clr   (clr_accum),
        .last  (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            ACCUM: begin
                if (clr_accum) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end else if (beat_add) begin
                    if (cnt_last) begin
                        out_data_d = sum[ACC_W-1:0];
                        out_ovf_d  = ovf_q | sum[ACC_W];
                        acc_d      = '0;
                        ovf_d      = 1'b0;
                        state_d    = HOLD;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                        ovf_d = ovf_q | sum[ACC_W];
                    end
                end
            end
            HOLD: begin
                // Result stays put until taken; clr cannot withdraw it.
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_adder5_frame_accumulator.sv
// Self-checking bench: two accumulators (ACC_W=9 and ACC_W=8) share one stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_adder5_frame_accumulator;

    localparam int BEATS = 8;

    logic       clk = 1'b0;
    logic       rst_n, clr, in_carry, in_valid, out_ready;
    logic [4:0] in_sum;

    logic       in_ready_a, out_valid_a, out_ovf_a;
    logic [8:0] out_data_a;
    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [7:0] out_data_b;

    always #5 clk = ~clk;

    adder5_frame_accumulator #(.BEATS(BEATS), .ACC_W(9)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_sum(in_sum), .in_carry(in_carry),
        .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_ovf(out_ovf_a), .out_valid(out_valid_a), .out_ready(out_ready)
    );

    adder5_frame_accumulator #(.BEATS(BEATS), .ACC_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_sum(in_sum), .in_carry(in_carry),
        .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_ovf(out_ovf_b), .out_valid(out_valid_b), .out_ready(out_ready)
    );

    typedef struct {
        int   data;
        logic ovf;
    } res_t;

    typedef struct {
        logic [5:0] oper;
        int         d9;
        logic       o9;
        int         d8;
        logic       o8;
    } vec_t;

    res_t q_a[$];
    res_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: plain integer sum of the frame, independent of widths.
    int tot = 0;
    int cnt_m = 0;
    bit hold_m = 0;
    int beats_acc = 0;
    int pops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        tot    = 0;
        cnt_m  = 0;
        hold_m = 0;
        q_a.delete();
        q_b.delete();
    endtask

    // Sample at the falling edge, update the model, then advance past the next rising edge.
    task automatic step();
        res_t r;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_in_ready_a", in_ready_a, 1);
            chk("rst_out_valid_a", out_valid_a, 0);
            chk("rst_out_data_a", out_data_a, 0);
            chk("rst_out_ovf_a", out_ovf_a, 0);
            chk("rst_in_ready_b", in_ready_b, 1);
            chk("rst_out_valid_b", out_valid_b, 0);
            chk("rst_out_data_b", out_data_b, 0);
            chk("rst_out_ovf_b", out_ovf_b, 0);
            model_reset();
        end else begin
            chk("in_ready_a", in_ready_a, !hold_m);
            chk("out_valid_a", out_valid_a, hold_m);
            chk("in_ready_b", in_ready_b, !hold_m);
            chk("out_valid_b", out_valid_b, hold_m);
            if (hold_m) begin
                if (q_a.size() == 0 || q_b.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    chk("hold_data_a", out_data_a, q_a[0].data);
                    chk("hold_ovf_a", out_ovf_a, q_a[0].ovf);
                    chk("hold_data_b", out_data_b, q_b[0].data);
                    chk("hold_ovf_b", out_ovf_b, q_b[0].ovf);
                    if (out_ready) begin
                        void'(q_a.pop_front());
                        void'(q_b.pop_front());
                        pops++;
                        hold_m = 0;
                    end
                end
            end else if (clr) begin
                tot   = 0;
                cnt_m = 0;
            end else if (in_valid) begin
                tot += int'({in_carry, in_sum});
                cnt_m++;
                beats_acc++;
                if (cnt_m == BEATS) begin
                    r.data = tot % 512;
                    r.ovf  = (tot >= 512);
                    q_a.push_back(r);
                    r.data = tot % 256;
                    r.ovf  = (tot >= 256);
                    q_b.push_back(r);
                    tot    = 0;
                    cnt_m  = 0;
                    hold_m = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [5:0] op);
        in_valid = 1'b1;
        {in_carry, in_sum} = op;
        step();
    endtask

    task automatic drain(input string name);
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (hold_m && k < 20) begin
            step();
            k++;
        end
        if (hold_m) chk({name, "_drain_timeout"}, 0, 1);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{6'd63, 504, 1'b0, 248, 1'b1};
        vt[1] = '{6'd2,  16,  1'b0, 16,  1'b0};
        vt[2] = '{6'd0,  0,   1'b0, 0,   1'b0};
        vt[3] = '{6'd32, 256, 1'b0, 0,   1'b1};
        vt[4] = '{6'd40, 320, 1'b0, 64,  1'b1};
        vt[5] = '{6'd1,  8,   1'b0, 8,   1'b0};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sum = '0; in_carry = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Full frames of a constant operand; result must be up right after the 8th beat.
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b0;
            for (int b = 0; b < BEATS; b++) beat(vt[i].oper);
            in_valid = 1'b0;
            chk("tbl_valid", out_valid_a, 1);
            chk("tbl_d9", out_data_a, vt[i].d9);
            chk("tbl_o9", out_ovf_a, vt[i].o9);
            chk("tbl_d8", out_data_b, vt[i].d8);
            chk("tbl_o8", out_ovf_b, vt[i].o8);
            out_ready = 1'b1;
            step();
            chk("tbl_released", out_valid_a, 0);
        end

        // Backpressure: held result, presented beats refused, clr in HOLD ignored.
        out_ready = 1'b0;
        for (int b = 0; b < BEATS; b++) beat(6'd5);
        for (int c = 0; c < 5; c++) begin
            clr = (c == 2);
            beat(6'd7);
        end
        clr = 1'b0;
        chk("bp_data_kept", out_data_a, 40);
        out_ready = 1'b1;
        beat(6'd7);
        chk("bp_released", in_ready_a, 1);
        for (int b = 0; b < BEATS; b++) beat(6'd7);
        in_valid = 1'b0;
        chk("bp_next_frame", out_data_a, 56);
        drain("bp");

        // Clear as a standalone pulse, then clear coinciding with a beat.
        beat(6'd10); beat(6'd10); beat(6'd10);
        in_valid = 1'b0; clr = 1'b1; step(); clr = 1'b0;
        for (int b = 0; b < BEATS; b++) beat(6'd1);
        in_valid = 1'b0;
        chk("clr_pulse_data", out_data_a, 8);
        chk("clr_pulse_ovf", out_ovf_a, 0);
        drain("clr1");
        beat(6'd10); beat(6'd10);
        clr = 1'b1; beat(6'd10); clr = 1'b0;
        for (int b = 0; b < BEATS; b++) beat(6'd1);
        in_valid = 1'b0;
        chk("clr_beat_data", out_data_a, 8);
        drain("clr2");

        // Reset mid-frame, then reset while a result is held.
        for (int b = 0; b < 5; b++) beat(6'd3);
        in_valid = 1'b0; rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        for (int b = 0; b < BEATS; b++) beat(6'd2);
        in_valid = 1'b0;
        chk("rst_mid_data", out_data_a, 16);
        drain("rst1");
        out_ready = 1'b0;
        for (int b = 0; b < BEATS; b++) beat(6'd9);
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Random gaps, random sink stalls, random operands over 100 frames.
        beats_acc = 0;
        pops = 0;
        begin
            int cyc = 0;
            while (cyc < 30000 && (beats_acc < 100 * BEATS || hold_m)) begin
                in_valid  = (beats_acc < 100 * BEATS) && ($urandom_range(0, 3) != 0);
                {in_carry, in_sum} = 6'($urandom_range(0, 63));
                out_ready = 1'($urandom_range(0, 1));
                step();
                cyc++;
            end
        end
        drain("rnd");
        chk("rnd_beats", beats_acc, 100 * BEATS);
        chk("rnd_frames", pops, 100);
        chk("rnd_sb_empty_a", q_a.size(), 0);
        chk("rnd_sb_empty_b", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
